// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Purpose:
//   Hazard and sequencing controller for a 5-stage pipeline. It decides, every
//   cycle, which pipeline latches (FD, DE, EM, MW) and the PC may advance and
//   which latches are cleared to a bubble. Inputs are cache handshakes,
//   load-use operands, branch/jump resolution and the halt instruction.
//   It also provides:
//     - a startup flush: one IDLE cycle after reset with every latch cleared
//     - a halt drain: MEM/WB keeps writing back DRAIN_CYCLES more cycles
//       after halt reaches MEM, then the core freezes in HALTED
//     - a data-memory wait watchdog that raises a sticky mem_timeout flag
//
// Parameters:
//   DRAIN_CYCLES : cycles MW keeps advancing after halt reaches MEM
//   WAIT_LIMIT   : consecutive dmem wait cycles before mem_timeout sets
//
// Ports:
//   CLK, nRST              clock (rising edge), async active-low reset
//   ihit, dhit             instruction / data access completed this cycle
//   mem_dren, mem_dwen     MEM-stage instruction reads / writes dmem
//   mem_halt               halt instruction in MEM
//   branching, jumping     taken branch / jump resolved in EX
//   ex_dren, ex_rd         EX-stage load and its destination register
//   id_rs, id_rt           ID-stage source registers
//   pc_en                  PC update enable
//   FDen..MWen             latch enables
//   FDflush..MWflush       latch flushes (effective only with the enable)
//   halt                   sticky halted flag
//   mem_timeout            sticky dmem watchdog flag
//   perf_stall, perf_flush performance counters
//
// Optional feature (macro HAZARD_PERF_EN):
//   When defined, perf_stall counts RUN/MEMWAIT cycles with pc_en low and
//   perf_flush counts non-IDLE cycles with FDflush or DEflush asserted.
//   When undefined both outputs are tied to zero and no counters exist.
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int WAIT_LIMIT   = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        mem_dren,
  input  logic        mem_dwen,
  input  logic        mem_halt,
  input  logic        branching,
  input  logic        jumping,
  input  logic        ex_dren,
  input  logic [4:0]  ex_rd,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  output logic        pc_en,
  output logic        FDen,
  output logic        DEen,
  output logic        EMen,
  output logic        MWen,
  output logic        FDflush,
  output logic        DEflush,
  output logic        EMflush,
  output logic        MWflush,
  output logic        halt,
  output logic        mem_timeout,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_flush
);

  // Counter widths. The drain counter only ever holds 0..DRAIN_CYCLES-1.
  localparam int WAIT_W  = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(WAIT_LIMIT);
  localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'((DRAIN_CYCLES > 1) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    MEMWAIT = 3'd2,
    DRAIN   = 3'd3,
    HALTED  = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                halt_q, halt_d;
  logic                mem_timeout_q, mem_timeout_d;

  // Combinational decode results. Latch vectors are ordered {FD, DE, EM, MW}.
  logic                pc_en_c;
  logic [3:0]          en_c;
  logic [3:0]          flush_c;
  logic                use_flow;

  logic                load_use;
  logic                dmem_stall;
  logic                redirect;

  // A load into r0 never creates a hazard since r0 is hardwired to zero.
  assign load_use   = ex_dren & (ex_rd != 5'd0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
  assign dmem_stall = (mem_dren | mem_dwen) & ~dhit;
  assign redirect   = branching | jumping;

  // -------------------------------------------------------------------------
  // Next-state and output decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    pc_en_c     = 1'b0;
    en_c        = 4'b0000;
    flush_c     = 4'b0000;
    use_flow    = 1'b0;

    case (state_q)
      IDLE: begin
        // Clear every latch once so the pipeline starts from bubbles.
        en_c    = 4'b1111;
        flush_c = 4'b1111;
        state_d = RUN;
      end

      RUN: begin
        if (mem_halt) begin
          // Let the halt move into WB; EM gets a bubble behind it.
          en_c        = 4'b0011;
          flush_c     = 4'b0010;
          state_d     = DRAIN;
          drain_cnt_d = '0;
        end else if (dmem_stall) begin
          // Whole pipe frozen; this cycle already counts as the first wait.
          state_d    = MEMWAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          use_flow = 1'b1;
        end
      end

      MEMWAIT: begin
        if (!dhit) begin
          if (wait_cnt_q != WAIT_MAX) begin
            wait_cnt_d = wait_cnt_q + WAIT_ONE;
          end
        end else begin
          // Access finished: resume with normal control-flow rules this cycle.
          use_flow   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end
      end

      DRAIN: begin
        en_c = 4'b0001;
        if (drain_cnt_q >= DRAIN_LAST) begin
          state_d     = HALTED;
          drain_cnt_d = '0;
        end else begin
          drain_cnt_d = drain_cnt_q + DRAIN_ONE;
        end
      end

      HALTED: begin
        // Frozen until reset; all inputs ignored.
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Control-flow rules shared by RUN and the dhit cycle of MEMWAIT.
    if (use_flow) begin
      if (redirect) begin
        // Fetch the target even on an icache miss; squash wrong-path FD/DE.
        pc_en_c = 1'b1;
        en_c    = 4'b1111;
        flush_c = 4'b1100;
      end else if (load_use) begin
        // Hold the dependent instruction in ID, inject a bubble into EX.
        en_c    = 4'b0111;
        flush_c = 4'b0100;
      end else if (!ihit) begin
        // No instruction arrived: feed a bubble into FD, keep the rest moving.
        en_c    = 4'b1111;
        flush_c = 4'b1000;
      end else begin
        pc_en_c = 1'b1;
        en_c    = 4'b1111;
      end
    end
  end

  // Sticky flags. The watchdog fires on the cycle the counter reaches the
  // limit, whether that is on entry from RUN or while waiting.
  always_comb begin
    halt_d        = halt_q | (state_d == HALTED);
    mem_timeout_d = mem_timeout_q | ((wait_cnt_d == WAIT_MAX) && (wait_cnt_d != '0));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= IDLE;
      drain_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      halt_q        <= 1'b0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      drain_cnt_q   <= drain_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      halt_q        <= halt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign pc_en       = pc_en_c;
  assign FDen        = en_c[3];
  assign DEen        = en_c[2];
  assign EMen        = en_c[1];
  assign MWen        = en_c[0];
  assign FDflush     = flush_c[3];
  assign DEflush     = flush_c[2];
  assign EMflush     = flush_c[1];
  assign MWflush     = flush_c[0];
  assign halt        = halt_q;
  assign mem_timeout = mem_timeout_q;

  // -------------------------------------------------------------------------
  // Performance counters
  // -------------------------------------------------------------------------
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  // Neither condition can be true in HALTED, so both counters hold there.
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (((state_q == RUN) || (state_q == MEMWAIT)) && !pc_en_c) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if ((state_q != IDLE) && (flush_c[3] || flush_c[2])) begin
      perf_flush_d = perf_flush_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
//
// Directed scoreboard bench. The driver applies one input vector per cycle
// shortly after the rising edge and pushes the hand-computed expected outputs
// into a queue; the monitor pops one entry on each falling edge and compares.
// Expected output vector layout:
//   {pc_en, FDen, DEen, EMen, MWen, FDflush, DEflush, EMflush, MWflush,
//    halt, mem_timeout}
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic        CLK;
  logic        nRST;
  logic        ihit, dhit, mem_dren, mem_dwen, mem_halt;
  logic        branching, jumping, ex_dren;
  logic [4:0]  ex_rd, id_rs, id_rt;
  logic        pc_en, FDen, DEen, EMen, MWen;
  logic        FDflush, DEflush, EMflush, MWflush;
  logic        halt, mem_timeout;
  logic [31:0] perf_stall, perf_flush;

  pipeline_hazard_ctrl #(
    .DRAIN_CYCLES (2),
    .WAIT_LIMIT   (4)
  ) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .mem_dren    (mem_dren),
    .mem_dwen    (mem_dwen),
    .mem_halt    (mem_halt),
    .branching   (branching),
    .jumping     (jumping),
    .ex_dren     (ex_dren),
    .ex_rd       (ex_rd),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .pc_en       (pc_en),
    .FDen        (FDen),
    .DEen        (DEen),
    .EMen        (EMen),
    .MWen        (MWen),
    .FDflush     (FDflush),
    .DEflush     (DEflush),
    .EMflush     (EMflush),
    .MWflush     (MWflush),
    .halt        (halt),
    .mem_timeout (mem_timeout),
    .perf_stall  (perf_stall),
    .perf_flush  (perf_flush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output patterns {pc_en, en FD/DE/EM/MW, flush FD/DE/EM/MW}
  localparam logic [8:0] P_IDLE  = 9'b0_1111_1111;
  localparam logic [8:0] P_NORM  = 9'b1_1111_0000;
  localparam logic [8:0] P_STALL = 9'b0_0000_0000;
  localparam logic [8:0] P_BR    = 9'b1_1111_1100;
  localparam logic [8:0] P_LU    = 9'b0_0111_0100;
  localparam logic [8:0] P_IMISS = 9'b0_1111_1000;
  localparam logic [8:0] P_HALTM = 9'b0_0011_0010;
  localparam logic [8:0] P_DRAIN = 9'b0_0001_0000;

`ifdef HAZARD_PERF_EN
  localparam logic [31:0] EXP_PS = 32'd3;
  localparam logic [31:0] EXP_PF = 32'd1;
`else
  localparam logic [31:0] EXP_PS = 32'd0;
  localparam logic [31:0] EXP_PF = 32'd0;
`endif

  typedef struct {
    string       name;
    logic [10:0] exp;
    bit          chk_perf;
    logic [31:0] ps;
    logic [31:0] pf;
  } txn_t;

  txn_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Staged inputs, applied by cyc() just after the next rising edge.
  logic       s_nrst, s_ihit, s_dhit, s_mem_dren, s_mem_dwen, s_mem_halt;
  logic       s_branching, s_jumping, s_ex_dren;
  logic [4:0] s_ex_rd, s_id_rs, s_id_rt;

  task automatic clr();
    s_nrst      = 1'b1;
    s_ihit      = 1'b1;
    s_dhit      = 1'b0;
    s_mem_dren  = 1'b0;
    s_mem_dwen  = 1'b0;
    s_mem_halt  = 1'b0;
    s_branching = 1'b0;
    s_jumping   = 1'b0;
    s_ex_dren   = 1'b0;
    s_ex_rd     = 5'd0;
    s_id_rs     = 5'd0;
    s_id_rt     = 5'd0;
  endtask

  task automatic cyc(input string nm, input logic [8:0] pat, input logic h, input logic t,
                     input bit pchk, input logic [31:0] ps, input logic [31:0] pf);
    txn_t tx;
    @(posedge CLK);
    #1;
    nRST      = s_nrst;
    ihit      = s_ihit;
    dhit      = s_dhit;
    mem_dren  = s_mem_dren;
    mem_dwen  = s_mem_dwen;
    mem_halt  = s_mem_halt;
    branching = s_branching;
    jumping   = s_jumping;
    ex_dren   = s_ex_dren;
    ex_rd     = s_ex_rd;
    id_rs     = s_id_rs;
    id_rt     = s_id_rt;
    tx.name     = nm;
    tx.exp      = {pat, h, t};
    tx.chk_perf = pchk;
    tx.ps       = ps;
    tx.pf       = pf;
    sb.push_back(tx);
  endtask

  // Monitor: one comparison per transaction, on the falling edge.
  initial begin
    txn_t        tx;
    logic [10:0] got;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        tx  = sb.pop_front();
        got = {pc_en, FDen, DEen, EMen, MWen, FDflush, DEflush, EMflush, MWflush, halt, mem_timeout};
        n_checks++;
        if (got !== tx.exp) begin
          n_fail++;
          $display("FAIL %s: outputs got %b required %b", tx.name, got, tx.exp);
        end else begin
          $display("txn %-10s outputs %b ok", tx.name, got);
        end
        if (tx.chk_perf) begin
          n_checks++;
          if ((perf_stall !== tx.ps) || (perf_flush !== tx.pf)) begin
            n_fail++;
            $display("FAIL %s_perf: stall/flush got %0d/%0d required %0d/%0d",
                     tx.name, perf_stall, perf_flush, tx.ps, tx.pf);
          end else begin
            $display("txn %-10s perf stall=%0d flush=%0d ok", tx.name, perf_stall, perf_flush);
          end
        end
      end
    end
  end

  initial begin
    // Inputs idle; create a clean negedge on nRST.
    clr();
    nRST = 1'b1; ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
    mem_halt = 1'b0; branching = 1'b0; jumping = 1'b0; ex_dren = 1'b0;
    ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    #1 nRST = 1'b0;

    // Reset and startup flush
    s_nrst = 1'b0;
    cyc("rst0",  P_IDLE, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("rst1",  P_IDLE, 1'b0, 1'b0, 1'b0, 0, 0);
    s_nrst = 1'b1;
    cyc("idle",  P_IDLE, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("run",   P_NORM, 1'b0, 1'b0, 1'b0, 0, 0);

    // 3-cycle dmem read stall, then the dhit cycle resumes normally
    s_mem_dren = 1'b1; s_dhit = 1'b0;
    cyc("dstall0", P_STALL, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("dstall1", P_STALL, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("dstall2", P_STALL, 1'b0, 1'b0, 1'b0, 0, 0);
    s_dhit = 1'b1;
    cyc("dhit",    P_NORM,  1'b0, 1'b0, 1'b0, 0, 0);

    // Branch during an icache miss still redirects the PC
    clr(); s_branching = 1'b1; s_ihit = 1'b0;
    cyc("br_imiss", P_BR, 1'b0, 1'b0, 1'b0, 0, 0);
    clr();
    cyc("perf_chk", P_NORM, 1'b0, 1'b0, 1'b1, EXP_PS, EXP_PF);

    // Load-use detection
    s_ex_dren = 1'b1; s_ex_rd = 5'd8; s_id_rt = 5'd8; s_id_rs = 5'd0;
    cyc("lu_rt", P_LU, 1'b0, 1'b0, 1'b0, 0, 0);
    s_id_rs = 5'd8; s_id_rt = 5'd3;
    cyc("lu_rs", P_LU, 1'b0, 1'b0, 1'b0, 0, 0);
    s_ex_rd = 5'd0; s_id_rs = 5'd0; s_id_rt = 5'd0;
    cyc("lu_r0", P_NORM, 1'b0, 1'b0, 1'b0, 0, 0);
    s_ex_dren = 1'b0; s_ex_rd = 5'd8; s_id_rt = 5'd8;
    cyc("no_load", P_NORM, 1'b0, 1'b0, 1'b0, 0, 0);

    // Control flow beats load-use; load-use beats icache miss
    s_ex_dren = 1'b1; s_branching = 1'b1;
    cyc("br_lu", P_BR, 1'b0, 1'b0, 1'b0, 0, 0);
    s_branching = 1'b0; s_jumping = 1'b1;
    cyc("jmp_lu", P_BR, 1'b0, 1'b0, 1'b0, 0, 0);
    s_jumping = 1'b0; s_ihit = 1'b0;
    cyc("lu_imiss", P_LU, 1'b0, 1'b0, 1'b0, 0, 0);
    s_ex_dren = 1'b0;
    cyc("imiss", P_IMISS, 1'b0, 1'b0, 1'b0, 0, 0);

    // dmem write stall beats branch; 5 wait cycles trip the watchdog (limit 4)
    clr(); s_mem_dwen = 1'b1; s_dhit = 1'b0; s_branching = 1'b1;
    cyc("st_br", P_STALL, 1'b0, 1'b0, 1'b0, 0, 0);
    s_branching = 1'b0;
    cyc("wait2", P_STALL, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("wait3", P_STALL, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("wait4", P_STALL, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("wait5", P_STALL, 1'b0, 1'b1, 1'b0, 0, 0);
    s_dhit = 1'b1; s_branching = 1'b1;
    cyc("mw_br", P_BR, 1'b0, 1'b1, 1'b0, 0, 0);
    clr();
    cyc("tmo_hold", P_NORM, 1'b0, 1'b1, 1'b0, 0, 0);

    // Halt beats a pending dmem stall, drains 2 cycles, then freezes
    s_mem_halt = 1'b1; s_mem_dren = 1'b1; s_dhit = 1'b0;
    cyc("halt_mem", P_HALTM, 1'b0, 1'b1, 1'b0, 0, 0);
    clr();
    cyc("drain0", P_DRAIN, 1'b0, 1'b1, 1'b0, 0, 0);
    cyc("drain1", P_DRAIN, 1'b0, 1'b1, 1'b0, 0, 0);
    s_branching = 1'b1; s_ihit = 1'b0; s_mem_halt = 1'b1;
    cyc("halted0", P_STALL, 1'b1, 1'b1, 1'b0, 0, 0);
    clr(); s_jumping = 1'b1; s_mem_dren = 1'b1; s_ex_dren = 1'b1; s_ex_rd = 5'd4; s_id_rs = 5'd4;
    cyc("halted1", P_STALL, 1'b1, 1'b1, 1'b0, 0, 0);
    clr();
    cyc("halted2", P_STALL, 1'b1, 1'b1, 1'b0, 0, 0);

    // Asynchronous reset mid-cycle clears sticky flags and counters
    s_nrst = 1'b0;
    cyc("arst",  P_IDLE, 1'b0, 1'b0, 1'b0, 0, 0);
    s_nrst = 1'b1;
    cyc("idle2", P_IDLE, 1'b0, 1'b0, 1'b0, 0, 0);
    cyc("run2",  P_NORM, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);

    // Let the monitor drain the scoreboard, bounded.
    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge CLK);
    @(posedge CLK);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: pending %0d required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
